apb_timer: RTL
==============

# apb_timer

APB3 timer slave that sits directly downstream of the AHB-to-APB bridge and consumes its PSEL/PENABLE/PADDR/PWRITE/PWDATA access cycles. It provides a prescaled 32-bit down-counter with one-shot and auto-reload modes plus a maskable interrupt. It returns PRDATA/PREADY/PSLVERR to the bridge, with a programmable number of wait states to exercise the bridge's APB3 PREADY path.

## Interface
- ADDRWIDTH, 16: width of PADDR.
- DATAWIDTH, 32: width of PWDATA/PRDATA. Fixed at 32 in this block.
- WAIT_STATES, 1: PCLKEN-qualified access-phase cycles with PREADY low per transfer (0..3).
- HCLK  input  1  clock. One clock domain only; all state updates on its rising edge.
- HRESETn  input  1  reset, asynchronous, active-low.
- PCLKEN  input  1  APB clock enable. All APB sampling and timer ticks are qualified by it.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PADDR  input  ADDRWIDTH  byte address. Only PADDR[11:0] is decoded.
- PWRITE  input  1  1 = write.
- PWDATA  input  32  write data.
- PRDATA  output  32  read data.
- PREADY  output  1  transfer complete.
- PSLVERR  output  1  error response.
- TIMER_IRQ  output  1  registered interrupt.

## Operation
- Register map (offset, access):
  - 0x00 CTRL, RW: [0] EN, [1] RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 LOAD, RW.
  - 0x08 VALUE, RO.
  - 0x0C STATUS, W1C: [0] IRQF.
  - 0x10 PRESCALE, RW: [7:0].
- Error cases (PSLVERR=1):
  - Any other offset.
  - A write to VALUE.
  - Errored accesses change no state and return PRDATA=0.
- Commit point is `done = PCLKEN & PSEL & PENABLE & PREADY`. Register writes take effect on the HCLK edge where done=1.
- Writing LOAD also loads VALUE with PWDATA on the same edge.
- Prescaler: 8-bit pcnt, running only while EN=1 and PCLKEN=1.
  - tick = EN & PCLKEN & (pcnt == PRESCALE).
  - On tick, pcnt is set to 0. Otherwise, when EN & PCLKEN, pcnt increments.
  - Writing EN 0→1 or writing PRESCALE clears pcnt.
- On tick:
  - VALUE != 0: VALUE -= 1 (32-bit, no wrap below 0).
  - VALUE == 0: IRQF is set. If RELOAD=1, VALUE <= LOAD. If RELOAD=0, EN <= 0 (one-shot) and VALUE stays 0.
- TIMER_IRQ <= IRQF & IRQ_EN, registered one cycle.
- Simultaneous events:
  - LOAD write and tick in the same cycle: the write wins and the tick's decrement/reload is dropped.
  - IRQF set and STATUS W1C in the same cycle: set wins.
  - CTRL write and a one-shot auto-clear of EN in the same cycle: the CTRL write wins.
- Wait-state FSM:
  - States: IDLE, WAIT (wcnt < WAIT_STATES), READY.
  - IDLE → WAIT when PSEL & PENABLE & PCLKEN and WAIT_STATES > 0.
  - IDLE → READY directly when WAIT_STATES == 0.
  - WAIT: wcnt increments each PCLKEN cycle while PSEL & PENABLE. Go to READY when wcnt == WAIT_STATES.
  - READY → IDLE on done.
  - PSEL low in any state → IDLE, wcnt = 0 (aborted transfer, no commit).

## Timing
- Reset values: PRDATA=0, PREADY=1 (so idle and setup phases see ready), PSLVERR=0, TIMER_IRQ=0.
- Reset values: CTRL=0, LOAD=0, VALUE=0, STATUS=0, PRESCALE=0, pcnt=0, wcnt=0, FSM=IDLE.
- PREADY is combinational from the FSM:
  - 0 in access phase while FSM is IDLE and WAIT_STATES > 0.
  - 0 while FSM is in WAIT.
  - 1 otherwise.
- With WAIT_STATES=N, an access phase lasts N+1 PCLKEN cycles.
- PRDATA is a combinational mux, valid whenever PSEL & !PWRITE & PENABLE & PREADY. It is 0 otherwise.
- PSLVERR is asserted only when PSEL & PENABLE & PREADY and the access is an error case.
- A read of VALUE returns the pre-edge value from the same cycle as done.
- Tick period is (PRESCALE+1) PCLKEN cycles.
- The IRQ pin rises 1 HCLK after IRQF is set.
- Async reset mid-transfer: all state clears immediately and PREADY returns to 1. No partial write survives.

## Test plan
- Reset, then read CTRL/LOAD/VALUE/STATUS/PRESCALE with WAIT_STATES=1 → all 0, each access shows exactly 1 PREADY-low cycle, PSLVERR=0.
- PCLKEN=1, PRESCALE=0, LOAD=3, CTRL=0x5 → VALUE steps 3,2,1,0 on consecutive cycles. IRQF=1 on the next tick, EN auto-clears, TIMER_IRQ=1 one cycle later.
- Auto-reload: PRESCALE=1, LOAD=2, CTRL=0x3 → VALUE decrements every 2 cycles, reloads to 2 after reaching 0, and IRQF is set each wrap. W1C 0x1 to STATUS clears it. A W1C coincident with a wrap leaves IRQF=1.
- Write to 0x08, then read from 0x14 → PSLVERR=1 on the final access cycle, VALUE unchanged, PRDATA=0.
- PCLKEN toggling 1-of-3 with WAIT_STATES=2 → PREADY low for exactly 2 enabled cycles. Prescaler counts only enabled cycles.
- Assert HRESETn low during a WAIT phase of a LOAD write → LOAD=0, PREADY=1 immediately, FSM=IDLE after release.

Source files
------------

// File: rtl/apb_timer.sv
// APB3 timer slave: prescaled 32-bit down-counter (one-shot / auto-reload) with maskable IRQ.
// Latency: PRDATA/PSLVERR are combinational in the completing cycle; writes commit on that edge; IRQ pin trails IRQF by one HCLK.
// Backpressure: PREADY is held low for WAIT_STATES PCLKEN-qualified access cycles of every transfer.
// Ports: HCLK/HRESETn clock and async active-low reset; PCLKEN APB enable; PSEL/PENABLE/PADDR/PWRITE/PWDATA
//        APB request; PRDATA/PREADY/PSLVERR APB response; TIMER_IRQ registered interrupt.
module apb_timer #(
  parameter int ADDRWIDTH   = 16,
  parameter int DATAWIDTH   = 32,
  parameter int WAIT_STATES = 1
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 PCLKEN,
  input  logic                 PSEL,
  input  logic                 PENABLE,
  input  logic [ADDRWIDTH-1:0] PADDR,
  input  logic                 PWRITE,
  input  logic [DATAWIDTH-1:0] PWDATA,
  output logic [DATAWIDTH-1:0] PRDATA,
  output logic                 PREADY,
  output logic                 PSLVERR,
  output logic                 TIMER_IRQ
);

  localparam logic [1:0] WS = 2'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_READY} state_t;

  state_t      state;
  logic [1:0]  wcnt;

  logic        en, reload, irq_en, irqf;
  logic [31:0] load_r, value_r;
  logic [7:0]  prescale, pcnt;

  logic        access, done, err, hit;
  logic        sel_ctrl, sel_load, sel_value, sel_status, sel_pre;
  logic        wr, wr_ctrl, wr_load, wr_status, wr_pre, en_rise;
  logic        tick, expire;
  logic [31:0] rdata;
  logic [11:0] off;

  // Only the low 12 address bits are decoded.
  logic unused_addr;
  assign unused_addr = ^PADDR[ADDRWIDTH-1:12];

  assign off    = PADDR[11:0];
  assign access = PSEL & PENABLE;

  // Ready drops on the first access cycle (still IDLE) and throughout WAIT.
  // Forcing it high under reset releases a bridge that is stuck mid-transfer.
  assign PREADY = ~HRESETn |
                  ~((state == S_WAIT) | ((state == S_IDLE) & access & (WS != 2'd0)));

  assign done = PCLKEN & access & PREADY;

  always_comb begin
    sel_ctrl   = (off == 12'h000);
    sel_load   = (off == 12'h004);
    sel_value  = (off == 12'h008);
    sel_status = (off == 12'h00C);
    sel_pre    = (off == 12'h010);
    hit        = sel_ctrl | sel_load | sel_value | sel_status | sel_pre;
    err        = ~hit | (PWRITE & sel_value);
  end

  assign wr        = done & PWRITE & ~err;
  assign wr_ctrl   = wr & sel_ctrl;
  assign wr_load   = wr & sel_load;
  assign wr_status = wr & sel_status;
  assign wr_pre    = wr & sel_pre;
  assign en_rise   = wr_ctrl & PWDATA[0] & ~en;

  assign tick   = en & PCLKEN & (pcnt == prescale);
  assign expire = tick & (value_r == 32'd0);

  always_comb begin
    rdata = '0;
    if (sel_ctrl)   rdata = {29'd0, irq_en, reload, en};
    if (sel_load)   rdata = load_r;
    if (sel_value)  rdata = value_r;
    if (sel_status) rdata = {31'd0, irqf};
    if (sel_pre)    rdata = {24'd0, prescale};
  end

  assign PRDATA  = (access & ~PWRITE & PREADY & ~err) ? rdata : '0;
  assign PSLVERR = access & PREADY & err;

  // Wait-state sequencer. The IDLE access cycle counts as the first wait
  // cycle, so a transfer sees exactly WS enabled cycles with PREADY low.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      wcnt  <= 2'd0;
    end else if (!PSEL) begin
      state <= S_IDLE;
      wcnt  <= 2'd0;
    end else if (PCLKEN && PENABLE) begin
      case (state)
        S_IDLE: begin
          if (WS != 2'd0) begin
            wcnt  <= 2'd1;
            state <= (WS == 2'd1) ? S_READY : S_WAIT;
          end
        end
        S_WAIT: begin
          wcnt <= wcnt + 2'd1;
          if (wcnt + 2'd1 == WS) state <= S_READY;
        end
        S_READY: begin
          state <= S_IDLE;
          wcnt  <= 2'd0;
        end
        default: begin
          state <= S_IDLE;
          wcnt  <= 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      en        <= 1'b0;
      reload    <= 1'b0;
      irq_en    <= 1'b0;
      irqf      <= 1'b0;
      load_r    <= '0;
      value_r   <= '0;
      prescale  <= '0;
      pcnt      <= '0;
      TIMER_IRQ <= 1'b0;
    end else begin
      if (wr_pre || en_rise)  pcnt <= '0;
      else if (tick)          pcnt <= '0;
      else if (en && PCLKEN)  pcnt <= pcnt + 8'd1;

      // A LOAD write overrides whatever the tick would have done to VALUE.
      if (wr_load)                           value_r <= PWDATA;
      else if (tick && value_r != 32'd0)     value_r <= value_r - 32'd1;
      else if (expire && reload)             value_r <= load_r;

      if (wr_load) load_r <= PWDATA;

      if (wr_ctrl) begin
        en     <= PWDATA[0];
        reload <= PWDATA[1];
        irq_en <= PWDATA[2];
      end else if (expire && !reload) begin
        en <= 1'b0;
      end

      // Expiry beats a coincident W1C so no interrupt is lost.
      if (expire)                      irqf <= 1'b1;
      else if (wr_status && PWDATA[0]) irqf <= 1'b0;

      if (wr_pre) prescale <= PWDATA[7:0];

      TIMER_IRQ <= irqf & irq_en;
    end
  end

endmodule
